// File: rtl/booth_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_pkg
// Description : Shared types and constants for the sequential radix-4 Booth
//               multiplier: FSM state type, digit-count helper and the Booth
//               recoding truth table.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth recoding tables, indexed by the 3-bit scan window {b[2i+1], b[2i], b[2i-1]}.
  // The windows 000 and 111 both mean a zero digit, so none of the flags are set for them.
  localparam logic [7:0] BOOTH_ONE_TBL = 8'b0110_0110;  // windows 1,2,5,6 -> |d| = 1
  localparam logic [7:0] BOOTH_TWO_TBL = 8'b0001_1000;  // windows 3,4     -> |d| = 2
  localparam logic [7:0] BOOTH_NEG_TBL = 8'b0111_0000;  // windows 4,5,6   -> d < 0

  // There is one extra digit so that zero-extended unsigned operands come out exact.
  function automatic int digits(input int w);
    return w / 2 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_digit_enc.sv
`default_nettype none
// ============================================================================
// Module      : booth_digit_enc
// Description : Combinational radix-4 Booth digit encoder. It turns a 3-bit
//               scan window into magnitude flags (one/two) and a sign flag (neg).
// Revision    : 1.0 - initial release
// ============================================================================
module booth_digit_enc
  import booth_seq_pkg::*;
(
  input  logic [2:0] win,
  output logic       one,
  output logic       two,
  output logic       neg
);

  assign one = BOOTH_ONE_TBL[win];
  assign two = BOOTH_TWO_TBL[win];
  assign neg = BOOTH_NEG_TBL[win];

endmodule
`default_nettype wire

// File: rtl/booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_mult
// Description : Sequential radix-4 Booth multiplier that retires one digit per
//               clock. It supports signed and unsigned operands and uses
//               valid/ready handshakes on both the operand and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_seq_mult
  import booth_seq_pkg::*;
#(
  parameter int W = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p
);

  localparam int D  = digits(W);
  localparam int CW = $clog2(D);
  localparam int AW = 2 * W + 2;

  state_t          state_q, state_d;
  logic [W+1:0]    a_q, a_d;        // multiplicand, extended to W+2 bits
  logic [W+2:0]    b_q, b_d;        // multiplier scan register; bit 0 is b[-1]
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  p_q, p_d;        // result register; holds until the next DONE

  logic            enc_one, enc_two, enc_neg;
  logic [AW-1:0]   a_ext;
  logic [AW-1:0]   pp_mag;
  logic [AW-1:0]   pp_shift;
  logic [AW-1:0]   pp_add;
  logic [AW-1:0]   sum;
  logic [CW:0]     shamt;
  logic            ext_a, ext_b;

  // The low window of the scan register always holds the current digit.
  booth_digit_enc u_enc (
    .win (b_q[2:0]),
    .one (enc_one),
    .two (enc_two),
    .neg (enc_neg)
  );

  // Partial-product mux, shift by 2i, and the accumulator adder.
  // The magnitude is shifted before inversion. This way the one's complement also
  // fills the vacated low bits with ones, and a single carry-in completes the
  // two's-complement negation of the shifted term.
  always_comb begin
    a_ext  = {{W{a_q[W+1]}}, a_q};
    pp_mag = '0;
    if (enc_two) begin
      pp_mag = a_ext << 1;
    end else if (enc_one) begin
      pp_mag = a_ext;
    end
    shamt    = {cnt_q, 1'b0};
    pp_shift = pp_mag << shamt;
    pp_add   = enc_neg ? ~pp_shift : pp_shift;
    sum      = acc_q + pp_add + {{(AW-1){1'b0}}, enc_neg};
  end

  // FSM next-state logic and datapath register updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    ext_a   = in_signed & in_a[W-1];
    ext_b   = in_signed & in_b[W-1];
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = {ext_a, ext_a, in_a};
          b_d     = {ext_b, ext_b, in_b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = sum;
        b_d   = {2'b00, b_q[W+2:2]};
        if (cnt_q == CW'(D - 1)) begin
          p_d     = sum[2*W-1:0];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_p     = p_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_seq_mult
// Description : Self-checking bench for booth_seq_mult at W=8. It uses directed
//               vectors with hand-computed products, backpressure and
//               mid-operation reset, and a short pseudo-random sweep that is
//               checked against native integer multiplication.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_seq_mult;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;

  int n_checks;
  int n_fail;

  booth_seq_mult #(.W(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands for one edge. Then count edges until out_valid, checking the
  // latency and the product. Hold out_ready low for 'hold' extra cycles, then
  // complete the handshake.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] exp, input int hold);
    int edges;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(edges), 32'd5);
    check({tag, "_p"}, 32'(out_p), 32'(exp));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (k == hold - 1) check({tag, "_p_held"}, 32'(out_p), 32'(exp));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int edges;
    logic [7:0] ra, rb;
    logic rs;
    longint prod;

    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_p",     32'(out_p),     32'd0);
    rst_n = 1'b1;

    // Directed vectors with hand-computed products
    run_op("s80x80", 8'h80, 8'h80, 1'b1, 16'h4000, 0);
    run_op("uFFxFF", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
    run_op("sFFxFF", 8'hFF, 8'hFF, 1'b1, 16'h0001, 0);
    run_op("sFFx7F", 8'hFF, 8'h7F, 1'b1, 16'hFF81, 0);
    run_op("u00xAB", 8'h00, 8'hAB, 1'b0, 16'h0000, 0);
    run_op("s7Fx7F", 8'h7F, 8'h7F, 1'b1, 16'h3F01, 1);
    run_op("s80x7F", 8'h80, 8'h7F, 1'b1, 16'hC080, 2);
    run_op("u80x80", 8'h80, 8'h80, 1'b0, 16'h4000, 0);
    run_op("uFFx01", 8'hFF, 8'h01, 1'b0, 16'h00FF, 0);
    run_op("s01x80", 8'h01, 8'h80, 1'b1, 16'hFF80, 0);

    // Backpressure: the result must stay put, and in_valid pulses must be ignored
    @(negedge clk);
    in_a = 8'd5; in_b = 8'd7; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("bp_latency", 32'(edges), 32'd5);
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_p",     32'(out_p),     32'h0023);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      if (k == 4) begin in_a = 8'h99; in_b = 8'h99; in_valid = 1'b1; end
      if (k == 5) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    run_op("bp_next", 8'd2, 8'd3, 1'b0, 16'h0006, 0);

    // Reset while digit 2 is being computed aborts the operation
    @(negedge clk);
    in_a = 8'h12; in_b = 8'h34; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_p",     32'(out_p),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_3x5", 8'd3, 8'd5, 1'b0, 16'h000F, 0);

    // Pseudo-random sweep with mixed sign mode and random result backpressure
    for (int i = 0; i < 120; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      if (rs) prod = longint'($signed(ra)) * longint'($signed(rb));
      else    prod = longint'(ra) * longint'(rb);
      run_op("rand", ra, rb, rs, prod[15:0], int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
